// File: rtl/rs_issue_scheduler_pkg.sv
// ============================================================================
// Packages: res_st_pkg, qu_common
// Purpose : Shared types for the reservation-station issue path.
//           res_st_pkg holds the reservation-station cell layout used by the
//           RS itself. qu_common holds the scheduler's default depth,
//           index type and issue FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package res_st_pkg;

  // One reservation-station entry. qj/qk are producer tags; zero means the
  // operand value in vj/vk is already available.
  typedef struct packed {
    logic        busy;
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
  } res_st_cell_t;

endpackage : res_st_pkg

package qu_common;

  localparam int QU_RS_DEPTH = 8;
  localparam int QU_IDX_W    = $clog2(QU_RS_DEPTH);

  typedef logic [QU_IDX_W-1:0] rs_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } issue_state_t;

endpackage : qu_common

`default_nettype wire

// File: rtl/rs_issue_scheduler_if.sv
// ============================================================================
// Interface: rs_issue_scheduler_if
// Purpose  : Bundles the RS contents, execute handshake and the two issue
//            slots between the reservation station / execute stage and the
//            issue scheduler. Signal names are from the scheduler's view.
// Modports : slave  - the scheduler (consumes RS state, drives issue slots)
//            master - the RS / execute side
// Signals  : i_rs_in[RS_DEPTH]  RS contents
//            i_ex_ready         execute accepts the presented ops
//            i_flush            squash presented ops
//            o_grant_out        entries issued this cycle (pulse)
//            o_op1_out/o_op2_out, o_op1_valid/o_op2_valid, o_op1_idx/o_op2_idx
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs_issue_scheduler_if
  import res_st_pkg::*;
#(
  parameter int RS_DEPTH = 8
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  res_st_cell_t        i_rs_in [RS_DEPTH];
  logic                i_ex_ready;
  logic                i_flush;
  logic [RS_DEPTH-1:0] o_grant_out;
  res_st_cell_t        o_op1_out;
  res_st_cell_t        o_op2_out;
  logic                o_op1_valid;
  logic                o_op2_valid;
  logic [IDX_W-1:0]    o_op1_idx;
  logic [IDX_W-1:0]    o_op2_idx;

  modport slave (
    input  i_rs_in, i_ex_ready, i_flush,
    output o_grant_out, o_op1_out, o_op2_out,
           o_op1_valid, o_op2_valid, o_op1_idx, o_op2_idx
  );

  modport master (
    output i_rs_in, i_ex_ready, i_flush,
    input  o_grant_out, o_op1_out, o_op2_out,
           o_op1_valid, o_op2_valid, o_op1_idx, o_op2_idx
  );

endinterface : rs_issue_scheduler_if

`default_nettype wire

// File: rtl/rs_issue_scheduler_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational round-robin finder: first set bit of i_mask at or
//           after i_ptr, wrapping modulo RS_DEPTH.
// Ports   : i_mask  [RS_DEPTH]  candidate bits
//           i_ptr   [IDX_W]     scan start position
//           o_found             any bit set
//           o_idx   [IDX_W]     index of the first set bit (0 if none)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int RS_DEPTH = 8
) (
  input  wire logic [RS_DEPTH-1:0]         i_mask,
  input  wire logic [$clog2(RS_DEPTH)-1:0] i_ptr,
  output logic                             o_found,
  output logic [$clog2(RS_DEPTH)-1:0]      o_idx
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [IDX_W-1:0] w_pos;

  // RS_DEPTH is a power of two, so plain IDX_W-bit addition wraps for free.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      w_pos = i_ptr + IDX_W'(k);
      if (!o_found && i_mask[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule : rr_picker

`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
// ============================================================================
// Module  : rs_issue_scheduler
// Purpose : Picks up to two ready RS entries per cycle with round-robin
//           priority and presents them, registered, to the execute stage's
//           two operand slots. Holds on execute backpressure, drops the
//           presented ops on flush, and pulses a grant vector back to the RS.
// Ports   : clk    clock
//           rst_n  asynchronous active-low reset
//           bus    rs_issue_scheduler_if.slave (RS contents, ex_ready, flush,
//                  grant_out, op1/op2 out/valid/idx)
// Config  : QU_DUAL_ISSUE_EN - when defined, slot 2 is populated; when
//           undefined only slot 1 issues and slot 2 stays empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_issue_scheduler
  import res_st_pkg::*;
  import qu_common::*;
#(
  parameter int RS_DEPTH = QU_RS_DEPTH
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  rs_issue_scheduler_if.slave   bus
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  issue_state_t        r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [RS_DEPTH-1:0] r_grant;
  res_st_cell_t        r_op1;
  res_st_cell_t        r_op2;
  logic                r_v1;
  logic                r_v2;
  logic [IDX_W-1:0]    r_idx1;
  logic [IDX_W-1:0]    r_idx2;

  logic [RS_DEPTH-1:0] w_ready;
  logic                w_f1;
  logic [IDX_W-1:0]    w_i1;
  logic                w_f2;
  logic [IDX_W-1:0]    w_i2;
  logic [RS_DEPTH-1:0] w_grant_sel;
  logic [IDX_W-1:0]    w_last;
  logic                w_upd;

  // An entry granted last edge is still busy in the RS this cycle (its busy
  // bit clears on the coming edge), so it must not be picked again.
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ready
    assign w_ready[gi] = bus.i_rs_in[gi].busy
                      && (bus.i_rs_in[gi].qj == '0)
                      && (bus.i_rs_in[gi].qk == '0)
                      && !r_grant[gi];
  end

  rr_picker #(.RS_DEPTH(RS_DEPTH)) u_pick1 (
    .i_mask  (w_ready),
    .i_ptr   (r_ptr),
    .o_found (w_f1),
    .o_idx   (w_i1)
  );

`ifdef QU_DUAL_ISSUE_EN
  logic [RS_DEPTH-1:0] w_mask2;
  logic [IDX_W-1:0]    w_ptr2;

  // Slot 2 scans from just past slot 1 with slot 1 removed, so it can never
  // alias slot 1 and naturally wraps around the RS.
  always_comb begin
    w_mask2       = w_ready;
    w_mask2[w_i1] = 1'b0;
  end
  assign w_ptr2 = w_i1 + IDX_W'(1);

  rr_picker #(.RS_DEPTH(RS_DEPTH)) u_pick2 (
    .i_mask  (w_mask2),
    .i_ptr   (w_ptr2),
    .o_found (w_f2),
    .o_idx   (w_i2)
  );
`else
  assign w_f2 = 1'b0;
  assign w_i2 = '0;
`endif

  always_comb begin
    w_grant_sel = '0;
    if (w_f1) w_grant_sel[w_i1] = 1'b1;
    if (w_f2) w_grant_sel[w_i2] = 1'b1;
  end

  assign w_last = w_f2 ? w_i2 : w_i1;

  // New selection loads whenever nothing is presented or execute is
  // consuming what is presented.
  assign w_upd = (r_state == IDLE) || bus.i_ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_idx1  <= '0;
      r_idx2  <= '0;
    end else if (bus.i_flush) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_idx1  <= '0;
      r_idx2  <= '0;
    end else if (w_upd) begin
      r_grant <= w_grant_sel;
      r_v1    <= w_f1;
      r_v2    <= w_f2;
      r_op1   <= w_f1 ? bus.i_rs_in[w_i1] : '0;
      r_op2   <= w_f2 ? bus.i_rs_in[w_i2] : '0;
      r_idx1  <= w_f1 ? w_i1 : '0;
      r_idx2  <= w_f2 ? w_i2 : '0;
      if (w_f1) begin
        r_ptr <= w_last + IDX_W'(1);
      end
      r_state <= w_f1 ? ISSUE : IDLE;
    end else begin
      // Presenting ops while execute is busy: hold everything, no grants.
      r_grant <= '0;
      r_state <= STALL;
    end
  end

  assign bus.o_grant_out = r_grant;
  assign bus.o_op1_out   = r_op1;
  assign bus.o_op2_out   = r_op2;
  assign bus.o_op1_valid = r_v1;
  assign bus.o_op2_valid = r_v2;
  assign bus.o_op1_idx   = r_idx1;
  assign bus.o_op2_idx   = r_idx2;

endmodule : rs_issue_scheduler

`default_nettype wire
